// File: rtl/trap_handler_if.sv
// rtl/trap_handler_if.sv - flush/redirect handshake between trap_handler and fetch
//
// Signals
//   flush           trap_handler -> fetch  kill all younger in-flight instructions
//   redirect_valid  trap_handler -> fetch  redirect_pc is valid
//   redirect_pc     trap_handler -> fetch  new fetch PC
//   redirect_ready  fetch -> trap_handler  fetch accepts the redirect
// Modports
//   master  trap_handler side
//   slave   fetch side
interface trap_handler_if;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_handler.sv
// rtl/trap_handler.sv - M-mode trap/mret handler hosting mstatus, mtvec, mepc, mcause, mtval
//
// Optional feature macro: TRAP_HANDLER_COUNT_EN adds read-only CSR 0x7C0 mtrapcnt,
// a saturating count of accepted traps.
//
// Ports
//   i_clk          in   core clock
//   i_rst_n        in   asynchronous active-low reset
//   i_pc           in   PC of the instruction trapping or executing mret
//   i_trap_req     in   trap request from dispatch
//   i_trap_cause   in   exception code
//   i_trap_tval    in   trap value
//   i_mret         in   mret retiring this cycle
//   i_csr_we       in   CSR write strobe
//   i_csr_addr     in   CSR address, shared by read and write
//   i_csr_wdata    in   CSR write data, already merged for csrrs/csrrc
//   o_csr_rdata    out  combinational read data, 0 for unmapped addresses
//   o_csr_hit      out  i_csr_addr maps to a CSR implemented here
//   o_busy         out  handler is not idle; upstream stalls issue
//   o_mie          out  mstatus.MIE
//   redir          master side of the flush/redirect handshake
module trap_handler #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter int          CAUSE_W     = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_pc,
  input  logic               i_trap_req,
  input  logic [CAUSE_W-1:0] i_trap_cause,
  input  logic [31:0]        i_trap_tval,
  input  logic               i_mret,
  input  logic               i_csr_we,
  input  logic [11:0]        i_csr_addr,
  input  logic [31:0]        i_csr_wdata,
  output logic [31:0]        o_csr_rdata,
  output logic               o_csr_hit,
  output logic               o_busy,
  output logic               o_mie,
  trap_handler_if.master     redir
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MTRAPCNT = 12'h7C0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               mie_q, mpie_q;
  logic [31:2]        mtvec_q;
  logic [31:2]        mepc_q;
  logic [CAUSE_W-1:0] mcause_q;
  logic [31:0]        mtval_q;
  logic [31:2]        target_q;

  logic trap_take, mret_take, csr_wr;

  // Outputs decode only the state register, so nothing from i_trap_req reaches
  // them combinationally and an asynchronous reset drops them at once.
  always_comb begin
    state_d        = state_q;
    trap_take      = 1'b0;
    mret_take      = 1'b0;
    csr_wr         = 1'b0;
    o_busy         = 1'b1;
    redir.flush          = 1'b0;
    redir.redirect_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        // A trap takes priority over mret and suppresses any CSR write.
        csr_wr = i_csr_we & ~i_trap_req;
        if (i_trap_req) begin
          trap_take = 1'b1;
          state_d   = FLUSH;
        end else if (i_mret) begin
          mret_take = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        redir.flush = 1'b1;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        redir.redirect_valid = 1'b1;
        if (redir.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC[31:2];
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      target_q <= '0;
    end else if (trap_take) begin
      mepc_q   <= i_pc[31:2];
      mcause_q <= i_trap_cause;
      mtval_q  <= i_trap_tval;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      target_q <= mtvec_q;
    end else begin
      if (csr_wr) begin
        case (i_csr_addr)
          ADDR_MSTATUS: begin
            mie_q  <= i_csr_wdata[3];
            mpie_q <= i_csr_wdata[7];
          end
          ADDR_MTVEC:  mtvec_q  <= i_csr_wdata[31:2];
          ADDR_MEPC:   mepc_q   <= i_csr_wdata[31:2];
          ADDR_MCAUSE: mcause_q <= i_csr_wdata[CAUSE_W-1:0];
          ADDR_MTVAL:  mtval_q  <= i_csr_wdata;
          default: ;
        endcase
      end
      // mret's mstatus update overrides a same-cycle mstatus write; the
      // redirect target is the mepc value before any same-cycle write.
      if (mret_take) begin
        mie_q    <= mpie_q;
        mpie_q   <= 1'b1;
        target_q <= mepc_q;
      end
    end
  end

`ifdef TRAP_HANDLER_COUNT_EN
  logic [31:0] trap_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  trap_cnt_q <= '0;
    else if (trap_take && (trap_cnt_q != '1))      trap_cnt_q <= trap_cnt_q + 32'd1;
  end
`endif

  always_comb begin
    o_csr_rdata = '0;
    o_csr_hit   = 1'b1;
    case (i_csr_addr)
      ADDR_MSTATUS: begin
        o_csr_rdata[12:11] = 2'b11;
        o_csr_rdata[7]     = mpie_q;
        o_csr_rdata[3]     = mie_q;
      end
      ADDR_MTVEC:  o_csr_rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:   o_csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE: o_csr_rdata = {{(32-CAUSE_W){1'b0}}, mcause_q};
      ADDR_MTVAL:  o_csr_rdata = mtval_q;
`ifdef TRAP_HANDLER_COUNT_EN
      ADDR_MTRAPCNT: o_csr_rdata = trap_cnt_q;
`endif
      default: o_csr_hit = 1'b0;
    endcase
  end

  assign o_mie             = mie_q;
  assign redir.redirect_pc = {target_q, 2'b00};

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_pc[1:0], ADDR_MTRAPCNT};

endmodule

// File: tb/tb_trap_handler.sv
// tb/tb_trap_handler.sv - scoreboard bench for trap_handler
module tb_trap_handler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        trap_req;
  logic [4:0]  trap_cause;
  logic [31:0] trap_tval;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        busy;
  logic        mie;

  trap_handler_if rif ();

  trap_handler #(.RESET_MTVEC(32'h0000_0100)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc         (pc),
    .i_trap_req   (trap_req),
    .i_trap_cause (trap_cause),
    .i_trap_tval  (trap_tval),
    .i_mret       (mret),
    .i_csr_we     (csr_we),
    .i_csr_addr   (csr_addr),
    .i_csr_wdata  (csr_wdata),
    .o_csr_rdata  (csr_rdata),
    .o_csr_hit    (csr_hit),
    .o_busy       (busy),
    .o_mie        (mie),
    .redir        (rif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Redirect handshake completes on the next posedge when both are high.
  always @(negedge clk) begin
    if (rst_n && rif.redirect_valid && rif.redirect_ready) begin
      if (exp_q.size() == 0) check("redir_queue", 32'(exp_q.size()), 32'd1);
      else                   check("redir_pc", rif.redirect_pc, exp_q.pop_front());
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    @(negedge clk);
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    sync();
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    sync();
    csr_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin sync(); n++; end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic fire(input logic t, input logic m, input logic [31:0] p,
                      input logic [4:0] c, input logic [31:0] v, input logic [31:0] exp_pc);
    sync();
    trap_req = t; mret = m; pc = p; trap_cause = c; trap_tval = v;
    exp_q.push_back(exp_pc);
    sync();
    trap_req = 1'b0; mret = 1'b0;
    check("flush_n1", {31'd0, rif.flush}, 32'd1);
    check("valid_n1", {31'd0, rif.redirect_valid}, 32'd0);
    sync();
    check("flush_n2", {31'd0, rif.flush}, 32'd0);
    check("valid_n2", {31'd0, rif.redirect_valid}, 32'd1);
    wait_idle("idle_timeout");
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; trap_req = 1'b0; trap_cause = '0; trap_tval = '0;
    mret = 1'b0; csr_we = 1'b0; csr_addr = 12'h300; csr_wdata = '0;
    rif.redirect_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    csr_rd("rst_mtvec", 12'h305, 32'h0000_0100);
    csr_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_rd("rst_mepc", 12'h341, 32'h0);
    csr_rd("rst_mcause", 12'h342, 32'h0);
    csr_rd("rst_mtval", 12'h343, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flush", {31'd0, rif.flush}, 32'd0);
    check("rst_valid", {31'd0, rif.redirect_valid}, 32'd0);
    csr_rd("unmapped_rd", 12'h123, 32'h0);
    check("unmapped_hit", {31'd0, csr_hit}, 32'd0);

    // enable MIE, then illegal instruction trap
    csr_wr(12'h300, 32'h0000_0008);
    csr_rd("mie_set", 12'h300, 32'h0000_1808);
    check("o_mie_set", {31'd0, mie}, 32'd1);
    fire(1'b1, 1'b0, 32'h0000_2004, 5'd2, 32'hDEAD_BEEF, 32'h0000_0100);
    csr_rd("ill_mepc", 12'h341, 32'h0000_2004);
    csr_rd("ill_mcause", 12'h342, 32'h2);
    csr_rd("ill_mtval", 12'h343, 32'hDEAD_BEEF);
    csr_rd("ill_mstatus", 12'h300, 32'h0000_1880);
    check("ill_o_mie", {31'd0, mie}, 32'd0);

    // mret back, then mret to a rewritten mepc (low bits forced 0)
    fire(1'b0, 1'b1, 32'h0000_0104, 5'd0, 32'h0, 32'h0000_2004);
    csr_rd("mret_mstatus", 12'h300, 32'h0000_1888);
    csr_wr(12'h341, 32'h0000_200B);
    csr_rd("mepc_wr", 12'h341, 32'h0000_2008);
    fire(1'b0, 1'b1, 32'h0000_0108, 5'd0, 32'h0, 32'h0000_2008);

    // backpressure with an ignored second trap and write
    sync();
    rif.redirect_ready = 1'b0;
    trap_req = 1'b1; pc = 32'h0000_3000; trap_cause = 5'd5; trap_tval = 32'h1;
    exp_q.push_back(32'h0000_0100);
    sync(); trap_req = 1'b0;
    sync();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rif.redirect_valid}, 32'd1);
      check("bp_pc", rif.redirect_pc, 32'h0000_0100);
      check("bp_busy", {31'd0, busy}, 32'd1);
      trap_req = (i == 1); trap_cause = 5'd7;
      csr_we = (i == 2); csr_addr = 12'h342; csr_wdata = 32'd9;
      sync();
    end
    trap_req = 1'b0; csr_we = 1'b0;
    rif.redirect_ready = 1'b1;
    sync();
    check("bp_done", {31'd0, busy}, 32'd0);
    csr_rd("bp_mcause", 12'h342, 32'd5);

    // collision: trap + mret + mtvec write
    sync();
    trap_req = 1'b1; mret = 1'b1; csr_we = 1'b1; csr_addr = 12'h305;
    csr_wdata = 32'h0000_0403; pc = 32'h0000_4000; trap_cause = 5'd11;
    exp_q.push_back(32'h0000_0100);
    sync();
    trap_req = 1'b0; mret = 1'b0; csr_we = 1'b0;
    wait_idle("col_timeout");
    csr_rd("col_mcause", 12'h342, 32'd11);
    csr_rd("col_mtvec", 12'h305, 32'h0000_0100);

    // WARL mtvec write then trap to the new vector
    csr_wr(12'h305, 32'h0000_0403);
    csr_rd("mtvec_warl", 12'h305, 32'h0000_0400);
    fire(1'b1, 1'b0, 32'h0000_5000, 5'd3, 32'h0, 32'h0000_0400);

    // asynchronous reset in FLUSH
    sync();
    trap_req = 1'b1; pc = 32'h0000_6000; trap_cause = 5'd4;
    exp_q.push_back(32'h0000_0400);
    sync();
    trap_req = 1'b0;
    check("ar_flush_hi", {31'd0, rif.flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_flush", {31'd0, rif.flush}, 32'd0);
    check("ar_valid", {31'd0, rif.redirect_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    csr_addr = 12'h305; #1;
    check("ar_mtvec", csr_rdata, 32'h0000_0100);
    csr_addr = 12'h342; #1;
    check("ar_mcause", csr_rdata, 32'h0);
    csr_addr = 12'h300; #1;
    check("ar_mstatus", csr_rdata, 32'h0000_1800);
    sync();
    rst_n = 1'b1;

    // trap counter
    for (int i = 0; i < 3; i++)
      fire(1'b1, 1'b0, 32'h0000_7000 + 32'(i * 4), 5'(i + 1), 32'h0, 32'h0000_0100);
    csr_wr(12'h7C0, 32'h0000_0055);
`ifdef TRAP_HANDLER_COUNT_EN
    csr_rd("mtrapcnt", 12'h7C0, 32'd3);
    check("mtrapcnt_hit", {31'd0, csr_hit}, 32'd1);
`else
    csr_rd("mtrapcnt_off", 12'h7C0, 32'd0);
    check("mtrapcnt_hit_off", {31'd0, csr_hit}, 32'd0);
`endif

    repeat (2) sync();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
